// File: rtl/meter_pkg.sv
// Shared types and default sizing for the clock period meter.
package meter_pkg;

    // Measurement state machine encoding
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } meter_state_t;

    localparam int unsigned DEFAULT_WIDTH          = 32;
    localparam int unsigned DEFAULT_SYNC_STAGES    = 2;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 100_000_000;

endpackage

// File: rtl/sync_rise_det.sv
// Multi-flop synchronizer for an asynchronous level, plus a rising-edge pulse.
// Reusable for any slow asynchronous input (strobes, push buttons).
module sync_rise_det
    import meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk_in,
    input  logic reset,
    input  logic sig_in,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s_d_reg;

    // Shift the raw input through the synchronizer chain and keep one delayed copy of the output
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync_reg <= '0;
            s_d_reg  <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], sig_in};
            s_d_reg  <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign s    = sync_reg[SYNC_STAGES-1];
    assign rise = s & ~s_d_reg;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk_in cycles.
// Reports each measurement with a one-cycle valid pulse; flags a sticky timeout when
// no rising edge arrives within TIMEOUT_CYCLES.
module clk_period_meter
    import meter_pkg::*;
#(
    parameter int unsigned WIDTH          = DEFAULT_WIDTH,
    parameter int unsigned SYNC_STAGES    = DEFAULT_SYNC_STAGES,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             timeout
);

    localparam logic [WIDTH-1:0] CNT_MAX      = '1;
    localparam logic [WIDTH-1:0] CNT_ONE      = WIDTH'(1);
    // Compared in 64 bits so a threshold beyond the counter range simply never fires
    // and the counters saturate instead.
    localparam logic [63:0]      TIMEOUT_LAST = 64'(TIMEOUT_CYCLES) - 64'd1;

    meter_state_t     state_reg, state_next;
    logic [WIDTH-1:0] p_cnt_reg, p_cnt_next;
    logic [WIDTH-1:0] h_cnt_reg, h_cnt_next;
    logic [WIDTH-1:0] period_reg, period_next;
    logic [WIDTH-1:0] high_reg, high_next;
    logic             valid_reg, valid_next;
    logic             timeout_reg, timeout_next;

    logic s;
    logic rise;
    logic p_at_max;
    logic h_at_max;
    logic at_timeout;

    sync_rise_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_in (clk_in),
        .reset  (reset),
        .sig_in (sig_in),
        .s      (s),
        .rise   (rise)
    );

    assign p_at_max   = (p_cnt_reg == CNT_MAX);
    assign h_at_max   = (h_cnt_reg == CNT_MAX);
    assign at_timeout = (64'(p_cnt_reg) == TIMEOUT_LAST);

    // State, counter and result registers
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_reg   <= IDLE;
            p_cnt_reg   <= '0;
            h_cnt_reg   <= '0;
            period_reg  <= '0;
            high_reg    <= '0;
            valid_reg   <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            p_cnt_reg   <= p_cnt_next;
            h_cnt_reg   <= h_cnt_next;
            period_reg  <= period_next;
            high_reg    <= high_next;
            valid_reg   <= valid_next;
            timeout_reg <= timeout_next;
        end
    end

    // Next-state logic: enable low dominates, a rise beats the timeout threshold
    always_comb begin
        state_next   = state_reg;
        p_cnt_next   = p_cnt_reg;
        h_cnt_next   = h_cnt_reg;
        period_next  = period_reg;
        high_next    = high_reg;
        valid_next   = 1'b0;
        timeout_next = timeout_reg;

        if (!enable) begin
            state_next = IDLE;
            p_cnt_next = '0;
            h_cnt_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    p_cnt_next = '0;
                    h_cnt_next = '0;
                    state_next = ARM;
                end
                ARM: begin
                    // First edge only starts the count; the rise cycle itself is high.
                    if (rise) begin
                        p_cnt_next = '0;
                        h_cnt_next = CNT_ONE;
                        state_next = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_next  = p_at_max ? CNT_MAX : p_cnt_reg + CNT_ONE;
                        high_next    = h_cnt_reg;
                        valid_next   = 1'b1;
                        timeout_next = 1'b0;
                        p_cnt_next   = '0;
                        h_cnt_next   = CNT_ONE;
                    end else if (at_timeout) begin
                        timeout_next = 1'b1;
                        p_cnt_next   = '0;
                        h_cnt_next   = '0;
                        state_next   = ARM;
                    end else begin
                        if (!p_at_max) begin
                            p_cnt_next = p_cnt_reg + CNT_ONE;
                        end
                        if (s && !h_at_max) begin
                            h_cnt_next = h_cnt_reg + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign period    = period_reg;
    assign high_time = high_reg;
    assign valid     = valid_reg;
    assign timeout   = timeout_reg;

endmodule
